// File: rtl/microseq_2910.sv
// microseq_2910: Am2910-compatible microprogram sequencer for the micro-BESM control store.
// Optional build macro MICROSEQ_STACK_ERR_EN enables the sticky stack over/underflow flag on err.
module microseq_2910 #(
  parameter int AW     = 12,
  parameter int SDEPTH = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    sqi,
  input  logic [AW-1:0] d,
  input  logic          ccen,
  input  logic          cc,
  input  logic          rld,
  input  logic          ci,
  output logic [AW-1:0] y,
  output logic          pe,
  output logic          me,
  output logic          ve,
  output logic          full,
  output logic          err
);

  localparam int SPW = $clog2(SDEPTH + 1);

  typedef enum logic [3:0] {
    SQ_JZ   = 4'd0,
    SQ_CJS  = 4'd1,
    SQ_JMAP = 4'd2,
    SQ_CJP  = 4'd3,
    SQ_PUSH = 4'd4,
    SQ_JSRP = 4'd5,
    SQ_CJV  = 4'd6,
    SQ_JRP  = 4'd7,
    SQ_RFCT = 4'd8,
    SQ_RPCT = 4'd9,
    SQ_CRTN = 4'd10,
    SQ_CJPP = 4'd11,
    SQ_LDCT = 4'd12,
    SQ_LOOP = 4'd13,
    SQ_CONT = 4'd14,
    SQ_TWB  = 4'd15
  } sqi_e;

  sqi_e           op;
  logic [AW-1:0]  upc_q, upc_d;
  logic [AW-1:0]  r_q, r_d;
  logic [AW-1:0]  stack_q [SDEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [SPW-1:0] tos_idx;
  logic [SPW-1:0] wr_idx;
  logic [AW-1:0]  tos;
  logic           pass;
  logic           rz;
  logic           do_push;
  logic           do_pop;
  logic           do_clear;
  logic           r_load;
  logic           r_dec;

  assign op      = sqi_e'(sqi);
  assign pass    = !ccen || cc;
  assign rz      = (r_q == '0);
  assign full    = (sp_q == SPW'(SDEPTH));
  assign tos_idx = sp_q - SPW'(1);
  assign tos     = (sp_q == '0) ? '0 : stack_q[tos_idx];
  // A push into a full stack overwrites the top entry instead of growing.
  assign wr_idx  = full ? SPW'(SDEPTH - 1) : sp_q;

  assign me = !reset && (op == SQ_JMAP);
  assign ve = !reset && (op == SQ_CJV);
  assign pe = !(me || ve);

  always_comb begin
    y        = upc_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_clear = 1'b0;
    r_load   = 1'b0;
    r_dec    = 1'b0;
    case (op)
      SQ_JZ: begin
        y        = '0;
        do_clear = 1'b1;
      end
      SQ_CJS: begin
        if (pass) begin
          y       = d;
          do_push = 1'b1;
        end
      end
      SQ_JMAP: y = d;
      SQ_CJP:  if (pass) y = d;
      SQ_PUSH: begin
        do_push = 1'b1;
        r_load  = pass;
      end
      SQ_JSRP: begin
        y       = pass ? d : r_q;
        do_push = 1'b1;
      end
      SQ_CJV:  if (pass) y = d;
      SQ_JRP:  y = pass ? d : r_q;
      SQ_RFCT: begin
        if (!rz) begin
          y     = tos;
          r_dec = 1'b1;
        end else begin
          do_pop = 1'b1;
        end
      end
      SQ_RPCT: begin
        if (!rz) begin
          y     = d;
          r_dec = 1'b1;
        end
      end
      SQ_CRTN: begin
        if (pass) begin
          y      = tos;
          do_pop = 1'b1;
        end
      end
      SQ_CJPP: begin
        if (pass) begin
          y      = d;
          do_pop = 1'b1;
        end
      end
      SQ_LDCT: r_load = 1'b1;
      SQ_LOOP: begin
        if (pass) do_pop = 1'b1;
        else      y      = tos;
      end
      SQ_CONT: y = upc_q;
      SQ_TWB: begin
        // Two-way branch: pass exits the loop; a fail with r exhausted branches to d.
        do_pop = pass || rz;
        r_dec  = !rz;
        if (!pass) y = rz ? d : tos;
      end
      default: y = upc_q;
    endcase
    if (reset) y = '0;
  end

  assign upc_d = y + {{(AW-1){1'b0}}, ci};

  always_comb begin
    r_d = r_q;
    if (rld || r_load) r_d = d;
    else if (r_dec)    r_d = r_q - AW'(1);
  end

  always_comb begin
    sp_d = sp_q;
    if (do_clear)                      sp_d = '0;
    else if (do_push && !full)         sp_d = sp_q + SPW'(1);
    else if (do_pop && (sp_q != '0))   sp_d = sp_q - SPW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q <= '0;
      r_q   <= '0;
      sp_q  <= '0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
      sp_q  <= sp_d;
    end
  end

  // Stack storage carries no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (!reset && do_push) stack_q[wr_idx] <= upc_q;
  end

`ifdef MICROSEQ_STACK_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((do_push && full) || (do_pop && (sp_q == '0))) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_microseq_2910.sv
// Bench for microseq_2910: directed plan steps followed by random instructions,
// each compared against a queue-based behavioural model of the sequencer.
module tb_microseq_2910;

  localparam int AW     = 12;
  localparam int SDEPTH = 5;
  localparam int unsigned MASK = (1 << AW) - 1;

  logic          clk;
  logic          reset;
  logic [3:0]    sqi;
  logic [AW-1:0] d;
  logic          ccen;
  logic          cc;
  logic          rld;
  logic          ci;
  logic [AW-1:0] y;
  logic          pe;
  logic          me;
  logic          ve;
  logic          full;
  logic          err;

  int passes;
  int total;

  // Behavioural model state
  int unsigned m_upc;
  int unsigned m_r;
  int unsigned m_stk[$];
  bit          m_err;

  microseq_2910 #(.AW(AW), .SDEPTH(SDEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .sqi  (sqi),
    .d    (d),
    .ccen (ccen),
    .cc   (cc),
    .rld  (rld),
    .ci   (ci),
    .y    (y),
    .pe   (pe),
    .me   (me),
    .ve   (ve),
    .full (full),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int unsigned m_tos();
    return (m_stk.size() == 0) ? 0 : m_stk[m_stk.size() - 1];
  endfunction

  task automatic m_push();
    if (m_stk.size() < SDEPTH) m_stk.push_back(m_upc);
    else begin
      m_stk[SDEPTH - 1] = m_upc;
      m_err = 1'b1;
    end
  endtask

  task automatic m_pop();
    if (m_stk.size() > 0) void'(m_stk.pop_back());
    else m_err = 1'b1;
  endtask

  function automatic int unsigned ref_y(input int s, input int unsigned dv, input bit pass);
    bit rz;
    rz = (m_r == 0);
    case (s)
      0:         return 0;
      1, 3, 6:   return pass ? dv : m_upc;
      2:         return dv;
      4, 12, 14: return m_upc;
      5, 7:      return pass ? dv : m_r;
      8:         return rz ? m_upc : m_tos();
      9:         return rz ? m_upc : dv;
      10:        return pass ? m_tos() : m_upc;
      11:        return pass ? dv : m_upc;
      13:        return pass ? m_upc : m_tos();
      default:   return pass ? m_upc : (rz ? dv : m_tos());
    endcase
  endfunction

  task automatic m_commit(input int s, input int unsigned dv, input bit pass, input bit rl,
                          input bit cin, input int unsigned ynext);
    bit rz;
    int unsigned r_new;
    rz    = (m_r == 0);
    r_new = m_r;
    case (s)
      0:  m_stk.delete();
      1:  if (pass) m_push();
      4: begin
        m_push();
        if (pass) r_new = dv;
      end
      5:  m_push();
      8: begin
        if (!rz) r_new = m_r - 1;
        else     m_pop();
      end
      9:  if (!rz) r_new = m_r - 1;
      10, 11, 13: if (pass) m_pop();
      12: r_new = dv;
      15: begin
        if (!rz) r_new = m_r - 1;
        if (pass || rz) m_pop();
      end
      default: ;
    endcase
    if (rl) r_new = dv;
    m_r   = r_new;
    m_upc = (ynext + cin) & MASK;
  endtask

  task automatic m_reset();
    m_upc = 0;
    m_r   = 0;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      sqi   = 4'($urandom_range(0, 15));
      d     = AW'($urandom);
      #1;
      chk("rst_y", 32'(y), 0);
      chk("rst_pe", 32'(pe), 1);
      chk("rst_me", 32'(me), 0);
      chk("rst_ve", 32'(ve), 0);
      @(posedge clk);
      m_reset();
    end
  endtask

  task automatic apply(input int s, input int unsigned dv, input bit en, input bit c,
                       input bit rl, input bit cin, input int want_y = -1);
    int unsigned ey;
    bit pass;
    @(negedge clk);
    reset = 1'b0;
    sqi   = 4'(s);
    d     = AW'(dv);
    ccen  = en;
    cc    = c;
    rld   = rl;
    ci    = cin;
    pass  = !en || c;
    #1;
    ey = ref_y(s, dv & MASK, pass);
    chk("y", 32'(y), ey);
    if (want_y >= 0) chk("y_plan", 32'(y), want_y);
    chk("me", 32'(me), (s == 2) ? 1 : 0);
    chk("ve", 32'(ve), (s == 6) ? 1 : 0);
    chk("pe", 32'(pe), (s == 2 || s == 6) ? 0 : 1);
    chk("full", 32'(full), (m_stk.size() == SDEPTH) ? 1 : 0);
`ifdef MICROSEQ_STACK_ERR_EN
    chk("err", 32'(err), 32'(m_err));
`else
    chk("err", 32'(err), 0);
`endif
    @(posedge clk);
    m_commit(s, dv & MASK, pass, rl, cin, ey);
  endtask

  initial begin
    passes = 0;
    total  = 0;
    reset  = 1'b1;
    sqi    = 4'd14;
    d      = '0;
    ccen   = 1'b0;
    cc     = 1'b0;
    rld    = 1'b0;
    ci     = 1'b1;
    m_reset();

    do_reset(2);
    // Sequential fetch from zero
    apply(14, 0, 0, 0, 0, 1, 'h000);
    apply(14, 0, 0, 0, 0, 1, 'h001);
    apply(14, 0, 0, 0, 0, 1, 'h002);
    apply(14, 0, 0, 0, 0, 1, 'h003);

    // Subroutine call and return from upc 0x010
    apply(2, 'h00F, 0, 0, 0, 1, 'h00F);
    apply(1, 'h200, 1, 1, 0, 1, 'h200);
    apply(10, 'h000, 1, 1, 0, 1, 'h010);

    // Counted loop: ldct 3, push without load, rfct x4
    apply(12, 3, 0, 0, 0, 1, 'h011);
    apply(4, 'h7FF, 1, 0, 0, 1, 'h012);
    apply(8, 0, 0, 0, 0, 1, 'h012);
    apply(8, 0, 0, 0, 0, 1, 'h012);
    apply(8, 0, 0, 0, 0, 1, 'h012);
    apply(8, 0, 0, 0, 0, 1, 'h013);

    // Conditional jump, tested then forced
    apply(3, 'h100, 1, 0, 0, 1, 'h014);
    apply(3, 'h100, 0, 0, 0, 1, 'h100);

    // Stack overflow, then jz clears sp but not err
    apply(0, 0, 0, 0, 0, 1, 'h000);
    for (int i = 0; i < 6; i++) apply(4, 'h055, 1, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 1, 'h000);
    apply(14, 0, 0, 0, 0, 1, 'h001);

    // Underflow via crtn on empty stack
    apply(10, 0, 0, 0, 0, 1);

    // rld overrides a decrement
    apply(12, 2, 0, 0, 0, 1);
    apply(9, 'h0A0, 0, 0, 1, 1, 'h0A0);
    apply(9, 'h0B0, 0, 0, 0, 1, 'h0B0);

    // Address wrap and map source
    apply(2, 'hFFE, 0, 0, 0, 1, 'hFFE);
    apply(14, 0, 0, 0, 0, 1, 'hFFF);
    apply(14, 0, 0, 0, 0, 1, 'h000);
    apply(2, 'h3A5, 0, 0, 0, 1, 'h3A5);
    apply(6, 'h123, 1, 1, 0, 1, 'h123);

    // Reset mid-loop discards everything
    apply(12, 5, 0, 0, 0, 1);
    apply(4, 0, 1, 0, 0, 1);
    do_reset(1);
    apply(14, 0, 0, 0, 0, 1, 'h000);

    // Random instruction stream
    for (int i = 0; i < 600; i++) begin
      int s;
      s = $urandom_range(0, 15);
      if (s == 0 && $urandom_range(0, 3) != 0) s = 14;
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 2));
      apply(s, $urandom & MASK, $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
